// File: rtl/dp_pkg.sv
// Shared types for the round-robin datapath sequencer: opcodes, requester id, buffer state.
package dp_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD = 3'b000;
    localparam opcode_t OP_SUB = 3'b001;
    localparam opcode_t OP_AND = 3'b010;
    localparam opcode_t OP_OR  = 3'b011;
    localparam opcode_t OP_XOR = 3'b100;

    typedef logic req_id_t;

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    // gnt is one-hot or zero, so bit 1 alone names the winner
    function automatic req_id_t gnt_index(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/dp_rr_sequencer_arb.sv
// Two-way round-robin arbiter; owns the priority pointer that favours the requester not served last.
module rr_arb2
    import dp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt,
    output req_id_t    ptr
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer moves only when something was actually granted
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (|gnt)
            ptr <= ~gnt_index(gnt);
    end

endmodule

// File: rtl/dp_rr_sequencer.sv
// Round-robin sequencer sharing one combinational datapath between two requesters.
// Optional grant counters (gnt_cnt0/gnt_cnt1) are enabled by defining DP_RR_GRANT_CNT_EN.
module dp_rr_sequencer
    import dp_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  opcode_t      req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  opcode_t      req1_op,
    output logic [N-1:0] dp_a,
    output logic [N-1:0] dp_b,
    output opcode_t      dp_op,
    input  logic [N-1:0] dp_y,
    input  logic         dp_co,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_y,
    output logic         res_co,
    output req_id_t      res_id
`ifdef DP_RR_GRANT_CNT_EN
    ,
    output logic [15:0]  gnt_cnt0,
    output logic [15:0]  gnt_cnt1
`endif
);

    state_t     state, state_nxt;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       can_accept;
    req_id_t    ptr;
    req_id_t    sel;

    assign res_valid  = (state == ST_FULL);
    assign can_accept = !res_valid || res_ready;

    // Reset gates the arbiter so no handshake completes in a reset cycle
    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .enable (can_accept && !rst),
        .gnt    (gnt),
        .ptr    (ptr)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign any_gnt    = |gnt;
    assign sel        = any_gnt ? gnt_index(gnt) : ptr;

    assign dp_a  = sel ? req1_a  : req0_a;
    assign dp_b  = sel ? req1_b  : req0_b;
    assign dp_op = sel ? req1_op : req0_op;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (any_gnt) state_nxt = ST_FULL;
            ST_FULL:  if (res_ready && !any_gnt) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Payload only changes on capture; a plain drain leaves the last result visible
    always_ff @(posedge clk) begin
        if (rst) begin
            res_y  <= '0;
            res_co <= 1'b0;
            res_id <= 1'b0;
        end else if (any_gnt) begin
            res_y  <= dp_y;
            res_co <= dp_co;
            res_id <= gnt_index(gnt);
        end
    end

`ifdef DP_RR_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= 16'd0;
            gnt_cnt1 <= 16'd0;
        end else begin
            if (gnt[0]) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (gnt[1]) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_rr_sequencer.sv
// Self-checking bench for dp_rr_sequencer: directed scenarios plus random traffic against a transaction-level model.
module tb_dp_rr_sequencer;
    import dp_pkg::*;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    opcode_t      req0_op, req1_op;
    logic [N-1:0] dp_a, dp_b, dp_y;
    opcode_t      dp_op;
    logic         dp_co;
    logic         res_valid, res_ready, res_co;
    logic [N-1:0] res_y;
    req_id_t      res_id;
`ifdef DP_RR_GRANT_CNT_EN
    logic [15:0]  gnt_cnt0, gnt_cnt1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    bit           m_valid;
    logic [N-1:0] m_y;
    bit           m_co;
    int           m_id;
    int           fav;
    int           cnt[2];
    int           last_gnt;

    always #5 clk = ~clk;

    // Stand-in for the shared datapath the parent would normally provide
    function automatic logic [N:0] dp_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} - {1'b0, b};
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a | b};
            3'b100:  return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    assign {dp_co, dp_y} = dp_model(dp_a, dp_b, dp_op);

    dp_rr_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_op      (dp_op),
        .dp_y       (dp_y),
        .dp_co      (dp_co),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_y      (res_y),
        .res_co     (res_co),
        .res_id     (res_id)
`ifdef DP_RR_GRANT_CNT_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic [2:0] op);
        if (idx == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge
    task automatic cycle();
        int           eg;
        bit           ca;
        logic [N-1:0] ga, gb;
        logic [2:0]   gop;
        @(negedge clk);
        ca = !m_valid || res_ready;
        if (rst || !ca)                  eg = -1;
        else if (req0_valid && req1_valid) eg = fav;
        else if (req0_valid)             eg = 0;
        else if (req1_valid)             eg = 1;
        else                             eg = -1;
        ga  = (eg == 1) ? req1_a  : req0_a;
        gb  = (eg == 1) ? req1_b  : req0_b;
        gop = (eg == 1) ? req1_op : req0_op;
        checkOutput("req0_ready", 32'(req0_ready), 32'(eg == 0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(eg == 1));
        checkOutput("res_valid", 32'(res_valid), 32'(m_valid));
        checkOutput("res_y", 32'(res_y), 32'(m_y));
        checkOutput("res_co", 32'(res_co), 32'(m_co));
        checkOutput("res_id", 32'(res_id), 32'(m_id));
        if (eg >= 0) begin
            checkOutput("dp_a", 32'(dp_a), 32'(ga));
            checkOutput("dp_b", 32'(dp_b), 32'(gb));
            checkOutput("dp_op", 32'(dp_op), 32'(gop));
        end
`ifdef DP_RR_GRANT_CNT_EN
        checkOutput("gnt_cnt0", 32'(gnt_cnt0), 32'(cnt[0]));
        checkOutput("gnt_cnt1", 32'(gnt_cnt1), 32'(cnt[1]));
`endif
        if (rst) begin
            m_valid = 0; m_y = '0; m_co = 0; m_id = 0; fav = 0;
            cnt[0] = 0; cnt[1] = 0;
        end else if (eg >= 0) begin
            {m_co, m_y} = dp_model(ga, gb, gop);
            m_valid = 1;
            m_id    = eg;
            fav     = 1 - eg;
            cnt[eg] = (cnt[eg] + 1) % 65536;
        end else if (m_valid && res_ready) begin
            m_valid = 0;
        end
        last_gnt = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 1'b0, '0, '0, OP_ADD);
        applyStimulus(1, 1'b0, '0, '0, OP_ADD);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int exp_id[4];
        int exp_y[4];
        exp_id = '{0, 1, 0, 1};
        exp_y  = '{2, 30, 2, 30};
        m_valid = 0; m_y = '0; m_co = 0; m_id = 0; fav = 0;
        cnt[0] = 0; cnt[1] = 0; last_gnt = -1;
        rst = 1'b1;
        res_ready = 1'b1;
        applyStimulus(0, 1'b0, '0, '0, OP_ADD);
        applyStimulus(1, 1'b0, '0, '0, OP_ADD);
        @(posedge clk);
        #1;
        doReset();

        // Single requester with a negative operand
        applyStimulus(0, 1'b1, 16'd5, 16'hFFFD, OP_ADD);
        cycle();
        applyStimulus(0, 1'b0, '0, '0, OP_ADD);
        checkOutput("single_y", 32'(res_y), 32'd2);
        checkOutput("single_id", 32'(res_id), 32'd0);
        cycle();

        // Contention alternates 0,1,0,1
        doReset();
        applyStimulus(0, 1'b1, 16'd1, 16'd1, OP_ADD);
        applyStimulus(1, 1'b1, 16'd10, 16'd20, OP_ADD);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checkOutput("rr_id", 32'(res_id), 32'(exp_id[i]));
            checkOutput("rr_y", 32'(res_y), 32'(exp_y[i]));
        end

        // Backpressure with both valid, then release to the favoured requester
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("stall_id", 32'(res_id), 32'd1);
            checkOutput("stall_y", 32'(res_y), 32'd30);
        end
        res_ready = 1'b1;
        cycle();
        checkOutput("release_id", 32'(res_id), 32'd0);

        // Signed overflow wrap, held under backpressure
        doReset();
        res_ready = 1'b0;
        applyStimulus(0, 1'b1, 16'd32767, 16'd1, OP_ADD);
        cycle();
        applyStimulus(0, 1'b0, '0, '0, OP_ADD);
        for (int i = 0; i < 2; i++) begin
            cycle();
            checkOutput("wrap_y", 32'(res_y), 32'h8000);
            checkOutput("wrap_co", 32'(res_co), 32'd0);
        end
        res_ready = 1'b1;
        cycle();
        checkOutput("drain_valid", 32'(res_valid), 32'd0);
        checkOutput("drain_hold_y", 32'(res_y), 32'h8000);

        // Reset while a result is buffered
        res_ready = 1'b0;
        applyStimulus(0, 1'b1, 16'd3, 16'd4, OP_ADD);
        cycle();
        checkOutput("pre_rst_y", 32'(res_y), 32'd7);
        rst = 1'b1;
        applyStimulus(1, 1'b1, 16'd9, 16'd9, OP_ADD);
        res_ready = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("rst_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_y", 32'(res_y), 32'd0);

        // 5 accepts for requester 0 and 3 for requester 1
        doReset();
        applyStimulus(0, 1'b1, 16'd2, 16'd3, OP_ADD);
        applyStimulus(1, 1'b1, 16'd4, 16'd5, OP_SUB);
        for (int i = 0; i < 6; i++) cycle();
        applyStimulus(1, 1'b0, '0, '0, OP_ADD);
        for (int i = 0; i < 2; i++) cycle();
`ifdef DP_RR_GRANT_CNT_EN
        checkOutput("cnt0_total", 32'(gnt_cnt0), 32'd5);
        checkOutput("cnt1_total", 32'(gnt_cnt1), 32'd3);
`endif

        // Random traffic honouring the hold-while-not-ready contract
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            res_ready = ($urandom_range(0, 3) != 0);
            if (!(req0_valid && last_gnt != 0))
                applyStimulus(0, $urandom_range(0, 2) != 0, N'($urandom), N'($urandom), 3'($urandom_range(0, 7)));
            if (!(req1_valid && last_gnt != 1))
                applyStimulus(1, $urandom_range(0, 2) != 0, N'($urandom), N'($urandom), 3'($urandom_range(0, 7)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dp_rr_sequencer.md
Name: dp_rr_sequencer

Overview:
- Shares one combinational arithmetic datapath (signed N-bit A/B, 3-bit opcode, Y, co) between two requesters.
- Arbitrates round-robin, drives the datapath operands for exactly the granted request, and registers Y/co plus a requester tag into a single-entry output buffer with valid/ready backpressure.
- Sits between the requesting units and the datapath instance. The datapath is instantiated by the parent and connected through the dp_* ports.

Parameters:
N, 16, operand/result width in bits (matches the datapath N)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle (valid&&ready)
req0_a  in  N  signed operand A
req0_b  in  N  signed operand B
req0_op  in  3  datapath opcode
req1_valid/req1_ready/req1_a/req1_b/req1_op: same as requester 0
dp_a  out  N  to datapath A
dp_b  out  N  to datapath B
dp_op  out  3  to datapath opcode
dp_y  in  N  datapath result Y (combinational from dp_a/dp_b/dp_op)
dp_co  in  1  datapath carry-out
res_valid  out  1  result buffer holds a result
res_ready  in  1  consumer takes result when res_valid&&res_ready
res_y  out  N  registered result
res_co  out  1  registered carry-out
res_id  out  1  requester that issued the result (0/1)

Behaviour:
- Reset (synchronous, rst=1 at clk edge): res_valid=0, res_y=0, res_co=0, res_id=0, priority pointer=0 (requester 0 favoured). req*_ready are combinational and therefore 0 while the buffer cannot accept. Reset mid-operation discards any buffered result; no handshake completes in the reset cycle (req*_ready forced 0 while rst=1).
- can_accept = !res_valid || res_ready.
- Grant (combinational):
  - If can_accept and exactly one reqX_valid, grant X.
  - If both are valid, grant the requester indicated by the priority pointer.
  - If !can_accept, grant none.
  - reqX_ready = grant==X; at most one ready per cycle.
- Datapath drive: dp_a/dp_b/dp_op mux the granted requester's fields. With no grant they hold requester-pointer fields (no functional meaning). No extra dp_* registering.
- Capture at a granted edge: res_y<=dp_y, res_co<=dp_co, res_id<=grant index, res_valid<=1.
- Latency: accepted at edge t, result visible from t+1. Throughput is 1 op/cycle while res_ready=1.
- Simultaneous drain+fill (res_valid&&res_ready and a grant in the same cycle): the new result overwrites, res_valid stays 1.
- Drain without grant: res_valid<=0; res_y/res_co/res_id hold their last values.
- Stall (res_valid&&!res_ready): no grants, buffer contents stable, pointer unchanged.
- Priority pointer updates only on a grant: pointer <= ~grant index, so the other requester is favoured next. A lone requester may be granted every cycle.
- Fairness: with both valid continuously and no backpressure, grants alternate 0,1,0,1.
- Requester contract: req fields stable while valid && !ready; the block does not check this.
- Arithmetic: the block performs no arithmetic; widths pass through unchanged, signedness preserved.
- FSM (explicit, 2 states):
  - EMPTY: res_valid=0. Grant -> FULL.
  - FULL: res_valid=1.
    - res_ready && no grant -> EMPTY.
    - res_ready && grant -> FULL (refill).
    - !res_ready -> FULL (stall).

Optional Feature:
- Macro: DP_RR_GRANT_CNT_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each). Each counts accepted operations for its requester, wraps 16'hFFFF->0, and resets to 0 on rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package dp_pkg:
  - opcode_t (3-bit typedef) and opcode constants, with OP_ADD=3'b000 the datapath addition.
  - req_id_t (1-bit).
  - state enum {ST_EMPTY, ST_FULL}.
- Natural sub-module: rr_arb2 (2-way round-robin arbiter).
  - Inputs: clk, rst, req[1:0], enable(=can_accept).
  - Output: one-hot gnt[1:0].
  - Owns the priority pointer.

Test Plan:
- Reset check: assert rst mid-stream with res_valid=1, res_y=7 -> next cycle res_valid=0, res_y=0, req0_ready=req1_ready=0 during rst.
- Single requester: req0 a=5, b=-3, op=000, res_ready=1 -> req0_ready=1 same cycle. Next cycle res_valid=1, res_y=2, res_co per datapath, res_id=0.
- Contention: both valid continuously (req0 a=1,b=1; req1 a=10,b=20; op=000), res_ready=1, 4 cycles -> res_id sequence 0,1,0,1 with res_y 2,30,2,30.
- Backpressure: buffer full, res_ready=0 for 3 cycles with both requesters valid -> no ready asserted, res_y/res_id stable, pointer unchanged. On release, the pointer-favoured requester is granted first.
- Overflow/wrap: N=16, a=32767, b=1, op=000 -> res_y=-32768, res_co as the datapath reports, held until res_ready.
- Feature build (DP_RR_GRANT_CNT_EN): 5 req0 plus 3 req1 accepts -> gnt_cnt0=5, gnt_cnt1=3. Preload path reaching 16'hFFFF then one more accept -> 0.
